// File: rtl/otter_demux_pkg.sv
// otter_demux_pkg: buffer states and sizes shared by the 1-to-8 handshake demux.
package otter_demux_pkg;
    typedef enum logic [1:0] {ST_EMPTY = 2'b00, ST_FULL = 2'b01, ST_SKID = 2'b10} state_t;
    localparam int SEL_W  = 3;
    localparam int N_SINK = 8;
endpackage

// File: rtl/demux_1t8_hs_dec_3t8.sv
// dec_3t8: one-hot 3-to-8 decoder, all-zero when disabled.
module dec_3t8
    import otter_demux_pkg::*;
(
    input  logic              en,
    input  logic [SEL_W-1:0]  sel,
    output logic [N_SINK-1:0] y
);
    always_comb y = en ? N_SINK'(1) << sel : '0;
endmodule

// File: rtl/demux_1t8_hs.sv
// demux_1t8_hs: registered 1-to-8 demux with main+skid buffering; IN_READY depends on
// registered state only, so there is no combinational path from OUT_READY to IN_READY.
module demux_1t8_hs
    import otter_demux_pkg::*;
#(
    parameter int n = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [n-1:0]      D_IN,
    input  logic [SEL_W-1:0]  SEL,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [n-1:0]      D_OUT,
    output logic [N_SINK-1:0] OUT_VALID,
    input  logic [N_SINK-1:0] OUT_READY,
    output logic [1:0]        COUNT
);
    state_t           state_q, state_d;
    logic [n-1:0]     main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
    logic             accept, deliver;

    dec_3t8 u_dec (
        .en  (state_q != ST_EMPTY),
        .sel (main_sel_q),
        .y   (OUT_VALID)
    );

    always_comb begin
        IN_READY = (state_q != ST_SKID) & ~RST;
        accept   = IN_VALID & IN_READY;
        deliver  = |(OUT_VALID & OUT_READY);
        D_OUT    = main_data_q;
        COUNT    = state_q;
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        case (state_q)
            ST_EMPTY: if (accept) begin
                state_d     = ST_FULL;
                main_data_d = D_IN;
                main_sel_d  = SEL;
            end
            ST_FULL: case ({accept, deliver})
                2'b11: begin
                    main_data_d = D_IN;
                    main_sel_d  = SEL;
                end
                2'b01: state_d = ST_EMPTY;
                2'b10: begin
                    state_d     = ST_SKID;
                    skid_data_d = D_IN;
                    skid_sel_d  = SEL;
                end
                default: ;
            endcase
            ST_SKID: if (deliver) begin
                state_d     = ST_FULL;
                main_data_d = skid_data_q;
                main_sel_d  = skid_sel_q;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end
endmodule

// File: tb/tb_demux_1t8_hs.sv
// tb_demux_1t8_hs: two-deep FIFO queue model checked every cycle, plus directed literal checks.
module tb_demux_1t8_hs;
    logic       CLK = 0;
    logic       RST = 1;
    logic [7:0] D_IN = 0;
    logic [2:0] SEL = 0;
    logic       IN_VALID = 0;
    logic       IN_READY;
    logic [7:0] D_OUT;
    logic [7:0] OUT_VALID;
    logic [7:0] OUT_READY = 0;
    logic [1:0] COUNT;

    int errors = 0;
    int checks = 0;

    demux_1t8_hs #(.n(8)) dut (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .SEL(SEL), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .D_OUT(D_OUT), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of {sel,data} with room for two words; D_OUT idles on the last word delivered.
    logic [10:0] q[$];
    logic [7:0]  last = 0;
    bit          armed = 0;

    always @(posedge CLK) begin
        if (RST) begin
            q.delete();
            last  = 0;
            armed = 1;
        end else if (armed) begin
            bit dlv, acc;
            dlv = q.size() > 0 && OUT_READY[q[0][10:8]];
            acc = IN_VALID && q.size() < 2;
            if (dlv) begin
                last = q[0][7:0];
                void'(q.pop_front());
            end
            if (acc) q.push_back({SEL, D_IN});
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            logic [7:0] e_ov, e_d;
            e_ov = q.size() > 0 ? 8'(1) << q[0][10:8] : 8'h00;
            e_d  = q.size() > 0 ? q[0][7:0] : last;
            chk("model_out_valid", 32'(OUT_VALID), 32'(e_ov));
            chk("model_d_out", 32'(D_OUT), 32'(e_d));
            chk("model_count", 32'(COUNT), 32'(q.size()));
            chk("model_in_ready", 32'(IN_READY), 32'(q.size() < 2 && !RST));
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic offer(input logic [2:0] s, input logic [7:0] d);
        SEL = s;
        D_IN = d;
        IN_VALID = 1;
    endtask

    initial begin
        cyc();
        cyc();
        RST = 0;
        // Reset mid-stream with two words buffered.
        OUT_READY = 8'h00;
        offer(3'd1, 8'h11);
        cyc();
        offer(3'd2, 8'h22);
        cyc();
        IN_VALID = 0;
        chk("pre_reset_count", 32'(COUNT), 32'd2);
        RST = 1;
        cyc();
        chk("rst_out_valid", 32'(OUT_VALID), 32'h00);
        chk("rst_d_out", 32'(D_OUT), 32'h00);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd0);
        cyc();
        chk("rst_in_ready2", 32'(IN_READY), 32'd0);
        RST = 0;
        cyc();
        chk("post_rst_in_ready", 32'(IN_READY), 32'd1);
        // Single word.
        OUT_READY = 8'hFF;
        offer(3'd5, 8'hA5);
        cyc();
        chk("single_out_valid", 32'(OUT_VALID), 32'h20);
        chk("single_d_out", 32'(D_OUT), 32'hA5);
        IN_VALID = 0;
        cyc();
        chk("single_count", 32'(COUNT), 32'd0);
        chk("single_hold", 32'(D_OUT), 32'hA5);
        // Streaming, one word per cycle.
        for (int i = 0; i < 8; i++) begin
            offer(3'(i), 8'(8'h10 + i));
            cyc();
            chk("stream_out_valid", 32'(OUT_VALID), 32'(8'(1) << i));
            chk("stream_d_out", 32'(D_OUT), 32'(8'h10 + i));
        end
        IN_VALID = 0;
        cyc();
        chk("stream_drain", 32'(COUNT), 32'd0);
        // Backpressure on sink 3.
        OUT_READY = 8'hF7;
        offer(3'd3, 8'h30);
        cyc();
        offer(3'd1, 8'h31);
        cyc();
        offer(3'd2, 8'h32);
        cyc();
        chk("bp_count", 32'(COUNT), 32'd2);
        chk("bp_in_ready", 32'(IN_READY), 32'd0);
        chk("bp_out_valid", 32'(OUT_VALID), 32'h08);
        chk("bp_d_out", 32'(D_OUT), 32'h30);
        OUT_READY = 8'hFF;
        cyc();
        chk("bp_drain1", 32'(D_OUT), 32'h31);
        chk("bp_drain1_ov", 32'(OUT_VALID), 32'h02);
        cyc();
        IN_VALID = 0;
        chk("bp_drain2", 32'(D_OUT), 32'h32);
        chk("bp_drain2_ov", 32'(OUT_VALID), 32'h04);
        // Only unselected sinks ready.
        OUT_READY = 8'hFB;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("wrong_ready_ov", 32'(OUT_VALID), 32'h04);
            chk("wrong_ready_d", 32'(D_OUT), 32'h32);
        end
        // Accept and deliver together while FULL.
        OUT_READY = 8'hFF;
        offer(3'd6, 8'h66);
        cyc();
        IN_VALID = 0;
        chk("ad_count", 32'(COUNT), 32'd1);
        chk("ad_out_valid", 32'(OUT_VALID), 32'h40);
        chk("ad_d_out", 32'(D_OUT), 32'h66);
        cyc();
        chk("ad_empty", 32'(COUNT), 32'd0);
        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            IN_VALID  = $urandom_range(0, 3) != 0;
            SEL       = 3'($urandom);
            D_IN      = 8'($urandom);
            OUT_READY = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            RST       = $urandom_range(0, 99) == 0;
            cyc();
        end
        RST = 0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
